// File: rtl/legacy_ttc_decoder.sv
// legacy_ttc_decoder
//   Receiver for the 2-bit-per-clock legacy TTC command stream. Three-symbol
//   commands (S0 always 11, then S1, S2) are decoded into one-clock
//   trigger / BCR / ECR / master-reset pulses. The block keeps a local BCID
//   counter and an event counter, and tags each trigger with both.
// Ports
//   clk_40       in   40 MHz clock, all logic on posedge
//   rst_40       in   async active-high reset
//   encode_ttc   in   [1:0] one symbol per clock (11 = mark, 00 = space)
//   trigger_out  out  1-clk pulse, trigger decoded
//   bcr_out      out  1-clk pulse, bunch-counter reset decoded
//   ecr_out      out  1-clk pulse, event-counter reset decoded
//   mreset_out   out  1-clk pulse, master reset decoded
//   bcid         out  [11:0] free-running local BCID
//   trig_bcid    out  [11:0] BCID captured at the last trigger
//   trig_evid    out  [EVID_WIDTH-1:0] event number of the last trigger
//   err_count    out  [ERR_WIDTH-1:0] saturating protocol-error count
//   decode_error out  1-clk pulse, invalid symbol or sequence
module legacy_ttc_decoder #(
    parameter int BX_PER_ORBIT = 3564,
    parameter int BCR_OFFSET   = 0,
    parameter int EVID_WIDTH   = 24,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  clk_40,
    input  logic                  rst_40,
    input  logic [1:0]            encode_ttc,
    output logic                  trigger_out,
    output logic                  bcr_out,
    output logic                  ecr_out,
    output logic                  mreset_out,
    output logic [11:0]           bcid,
    output logic [11:0]           trig_bcid,
    output logic [EVID_WIDTH-1:0] trig_evid,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  decode_error
);

    localparam logic [11:0] BCID_MAX  = 12'(BX_PER_ORBIT - 1);
    localparam logic [11:0] BCID_LOAD = 12'(BCR_OFFSET);

    typedef enum logic [1:0] {IDLE, SYM1, SYM2} state_t;

    state_t state, state_nxt;
    logic   s1_mark, s1_mark_nxt;   // latched S1: 1 = 11, 0 = 00
    logic   trig_d, bcr_d, ecr_d, mrst_d, err_d;
    logic   sym_mark, sym_bad;

    logic [EVID_WIDTH-1:0] ev_cnt;

    assign sym_mark = (encode_ttc == 2'b11);
    assign sym_bad  = (encode_ttc == 2'b01) || (encode_ttc == 2'b10);

    // Next-state and decode strobes; the strobes are registered into the
    // pulse outputs, so a command shows up the clock after its S2.
    always_comb begin
        state_nxt   = state;
        s1_mark_nxt = s1_mark;
        trig_d      = 1'b0;
        bcr_d       = 1'b0;
        ecr_d       = 1'b0;
        mrst_d      = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (sym_mark)     state_nxt = SYM1;
                else if (sym_bad) err_d     = 1'b1;
            end
            SYM1: begin
                if (sym_bad) begin
                    err_d     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    s1_mark_nxt = sym_mark;
                    state_nxt   = SYM2;
                end
            end
            SYM2: begin
                state_nxt = IDLE;
                if (sym_bad) begin
                    err_d = 1'b1;
                end else begin
                    case ({s1_mark, sym_mark})
                        2'b00:   trig_d = 1'b1;
                        2'b10:   bcr_d  = 1'b1;
                        2'b11:   ecr_d  = 1'b1;
                        default: mrst_d = 1'b1;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            state   <= IDLE;
            s1_mark <= 1'b0;
        end else begin
            state   <= state_nxt;
            s1_mark <= s1_mark_nxt;
        end
    end

    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            trigger_out  <= 1'b0;
            bcr_out      <= 1'b0;
            ecr_out      <= 1'b0;
            mreset_out   <= 1'b0;
            decode_error <= 1'b0;
            bcid         <= '0;
            trig_bcid    <= '0;
            trig_evid    <= '0;
            ev_cnt       <= '0;
            err_count    <= '0;
        end else begin
            trigger_out  <= trig_d;
            bcr_out      <= bcr_d;
            ecr_out      <= ecr_d;
            mreset_out   <= mrst_d;
            decode_error <= err_d;

            // BCR load wins over the orbit wrap
            if (bcr_d)                 bcid <= BCID_LOAD;
            else if (bcid == BCID_MAX) bcid <= '0;
            else                       bcid <= bcid + 12'd1;

            if (trig_d) begin
                trig_bcid <= bcid;
                trig_evid <= ev_cnt;
                ev_cnt    <= ev_cnt + 1'b1;
            end
            if (ecr_d) ev_cnt <= '0;

            if (err_d && (err_count != {ERR_WIDTH{1'b1}}))
                err_count <= err_count + 1'b1;

            // master reset never coincides with an error or another command
            if (mrst_d) begin
                ev_cnt    <= '0;
                err_count <= '0;
                trig_bcid <= '0;
                trig_evid <= '0;
            end
        end
    end

endmodule
